// File: rtl/horn_phase_sequencer_pkg.sv
// Shared types for the horn phase sequencer. CONFIG and OSCILLATOR carry the
// lookup-stage types; horn_phase_sequencer_pkg holds sequencer-local helpers.
package CONFIG;
    localparam int LONG_PERCENT_WIDTH = 8;
    typedef logic [LONG_PERCENT_WIDTH-1:0] long_percent_t;
endpackage

package OSCILLATOR;
    typedef enum logic {
        FRONT = 1'b0,
        BACK  = 1'b1
    } oscillator_state_t;

    localparam int PHASE_FRAC_WIDTH = 12;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_FRONT   = 2'd1,
        SEQ_BACK    = 2'd2,
        SEQ_RELEASE = 2'd3
    } seq_state_t;
endpackage

package horn_phase_sequencer_pkg;
    localparam int HPS_DEFAULT_PHASE_WIDTH = CONFIG::LONG_PERCENT_WIDTH;
    localparam int HPS_DEFAULT_FRAC_WIDTH  = OSCILLATOR::PHASE_FRAC_WIDTH;

    function automatic int acc_width(input int phase_width, input int frac_width);
        return phase_width + frac_width;
    endfunction
endpackage

// File: rtl/horn_phase_sequencer_if.sv
// Control/output bundle between a voice controller (master) and the phase
// sequencer (slave).
interface horn_phase_sequencer_if #(
    parameter int PHASE_WIDTH = CONFIG::LONG_PERCENT_WIDTH,
    parameter int INC_WIDTH   = PHASE_WIDTH + OSCILLATOR::PHASE_FRAC_WIDTH
);
    logic                          sample_tick;
    logic                          note_on;
    logic                          note_off;
    logic [INC_WIDTH-1:0]          increment;
    OSCILLATOR::oscillator_state_t state;
    logic [PHASE_WIDTH-1:0]        phase;
    logic                          active;
    logic                          front_done;

    modport master (
        output sample_tick, note_on, note_off, increment,
        input  state, phase, active, front_done
    );

    modport slave (
        input  sample_tick, note_on, note_off, increment,
        output state, phase, active, front_done
    );
endinterface

// File: rtl/horn_phase_sequencer_phase_accumulator.sv
// Modulo-2^ACC_WIDTH phase accumulator with a latched increment; wrap_o is the
// carry-out of the add, valid in the cycle advance_i is high.
module phase_accumulator #(
    parameter int ACC_WIDTH = 20
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [ACC_WIDTH-1:0] increment_i,
    input  logic                 advance_i,
    output logic [ACC_WIDTH-1:0] acc_o,
    output logic                 wrap_o
);
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] inc_q, inc_d;
    logic [ACC_WIDTH:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d = acc_q;
        inc_d = inc_q;
        // Clear wins over advance so a restart or note end lands exactly on zero.
        if (clear_i) begin
            acc_d = '0;
        end else if (advance_i) begin
            acc_d = sum[ACC_WIDTH-1:0];
        end
        if (load_i) begin
            inc_d = increment_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            inc_q <= '0;
        end else begin
            acc_q <= acc_d;
            inc_q <= inc_d;
        end
    end

    assign acc_o  = acc_q;
    assign wrap_o = advance_i & sum[ACC_WIDTH];
endmodule

// File: rtl/horn_phase_sequencer.sv
// Per-voice FRONT/BACK phase sequencer feeding the horn wavetable lookup.
// Optional HORN_SOFT_RELEASE_EN: note_off in BACK runs on to the loop boundary.
module horn_phase_sequencer
    import OSCILLATOR::*;
    import horn_phase_sequencer_pkg::*;
#(
    parameter int PHASE_WIDTH = HPS_DEFAULT_PHASE_WIDTH,
    parameter int FRAC_WIDTH  = HPS_DEFAULT_FRAC_WIDTH,
    parameter int INC_WIDTH   = PHASE_WIDTH + FRAC_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    horn_phase_sequencer_if.slave  seq_if
);
    localparam int ACC = acc_width(PHASE_WIDTH, FRAC_WIDTH);

    seq_state_t        fsm_q;
    oscillator_state_t state_q;
    logic              active_q;
    logic              front_done_q;

    logic [ACC-1:0]    inc_ext;
    logic [ACC-1:0]    acc;
    logic              acc_wrap;
    logic              acc_clear;
    logic              acc_advance;
    logic              note_on;
    logic              note_off_live;
    logic              off_clears;
    logic              release_end;
    logic              unused_frac;

    generate
        if (INC_WIDTH >= ACC) begin : g_inc_trunc
            logic unused_inc_hi;
            assign inc_ext       = seq_if.increment[ACC-1:0];
            assign unused_inc_hi = ^{1'b0, seq_if.increment};
        end else begin : g_inc_zext
            assign inc_ext = {{(ACC-INC_WIDTH){1'b0}}, seq_if.increment};
        end
    endgenerate

    assign note_on       = seq_if.note_on;
    // note_off only matters while a note is audibly in FRONT or BACK.
    assign note_off_live = seq_if.note_off & ((fsm_q == SEQ_FRONT) | (fsm_q == SEQ_BACK));
    assign acc_advance   = seq_if.sample_tick & ~note_on & ~note_off_live & (fsm_q != SEQ_IDLE);

`ifdef HORN_SOFT_RELEASE_EN
    assign off_clears  = note_off_live & (fsm_q == SEQ_FRONT);
    assign release_end = (fsm_q == SEQ_RELEASE) & acc_wrap;
`else
    assign off_clears  = note_off_live;
    assign release_end = 1'b0;
`endif

    assign acc_clear = note_on | off_clears | release_end;

    phase_accumulator #(
        .ACC_WIDTH (ACC)
    ) u_phase_accumulator (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear_i     (acc_clear),
        .load_i      (note_on),
        .increment_i (inc_ext),
        .advance_i   (acc_advance),
        .acc_o       (acc),
        .wrap_o      (acc_wrap)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q        <= SEQ_IDLE;
            state_q      <= FRONT;
            active_q     <= 1'b0;
            front_done_q <= 1'b0;
        end else begin
            front_done_q <= 1'b0;
            if (note_on) begin
                fsm_q    <= SEQ_FRONT;
                state_q  <= FRONT;
                active_q <= 1'b1;
            end else begin
                case (fsm_q)
                    SEQ_IDLE: begin
                    end
                    SEQ_FRONT: begin
                        if (seq_if.note_off) begin
                            fsm_q    <= SEQ_IDLE;
                            state_q  <= FRONT;
                            active_q <= 1'b0;
                        end else if (acc_wrap) begin
                            // Remainder stays in the accumulator: BACK starts mid-cycle, no jump.
                            fsm_q        <= SEQ_BACK;
                            state_q      <= BACK;
                            front_done_q <= 1'b1;
                        end
                    end
                    SEQ_BACK: begin
                        if (seq_if.note_off) begin
`ifdef HORN_SOFT_RELEASE_EN
                            fsm_q    <= SEQ_RELEASE;
`else
                            fsm_q    <= SEQ_IDLE;
                            state_q  <= FRONT;
                            active_q <= 1'b0;
`endif
                        end
                    end
`ifdef HORN_SOFT_RELEASE_EN
                    SEQ_RELEASE: begin
                        if (acc_wrap) begin
                            fsm_q    <= SEQ_IDLE;
                            state_q  <= FRONT;
                            active_q <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        fsm_q    <= SEQ_IDLE;
                        state_q  <= FRONT;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign unused_frac       = ^{1'b0, acc[FRAC_WIDTH-1:0]};
    assign seq_if.phase      = acc[ACC-1:FRAC_WIDTH];
    assign seq_if.state      = state_q;
    assign seq_if.active     = active_q;
    assign seq_if.front_done = front_done_q;
endmodule

// File: tb/tb_horn_phase_sequencer.sv
// Directed, scoreboard-checked bench for horn_phase_sequencer (8.8 phase format).
module tb_horn_phase_sequencer;
    import OSCILLATOR::*;

    localparam int PW = 8;
    localparam int FW = 8;
    localparam int IW = 16;
    localparam int M_IDLE  = 0;
    localparam int M_FRONT = 1;
    localparam int M_BACK  = 2;
    localparam int M_REL   = 3;
`ifdef HORN_SOFT_RELEASE_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    horn_phase_sequencer_if #(.PHASE_WIDTH(PW), .INC_WIDTH(IW)) seq_if ();

    horn_phase_sequencer #(
        .PHASE_WIDTH (PW),
        .FRAC_WIDTH  (FW),
        .INC_WIDTH   (IW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .seq_if  (seq_if)
    );

    typedef struct packed {
        logic       st;
        logic [7:0] ph;
        logic       act;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    int vectors = 0;
    int miscompares = 0;
    int fd_seen = 0;
    int m_mode = M_IDLE;
    int m_acc = 0;
    int m_inc = 0;
    bit m_fd = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_acc  = 0;
        m_inc  = 0;
        m_fd   = 1'b0;
    endtask

    // Golden behaviour in plain integer arithmetic: 16-bit phase, 8.8 format.
    task automatic model_step(input bit tick, input bit on, input bit off, input int inc);
        int sum;
        m_fd = 1'b0;
        if (on) begin
            m_mode = M_FRONT;
            m_acc  = 0;
            m_inc  = inc;
        end else if (off && (m_mode == M_FRONT || m_mode == M_BACK)) begin
            if (m_mode == M_BACK && SOFT) begin
                m_mode = M_REL;
            end else begin
                m_mode = M_IDLE;
                m_acc  = 0;
            end
        end else if (tick && m_mode != M_IDLE) begin
            sum   = m_acc + m_inc;
            m_acc = sum % 65536;
            if (sum >= 65536) begin
                if (m_mode == M_FRONT) begin
                    m_mode = M_BACK;
                    m_fd   = 1'b1;
                end else if (m_mode == M_REL) begin
                    m_mode = M_IDLE;
                    m_acc  = 0;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.st  = (m_mode == M_BACK || m_mode == M_REL);
        e.ph  = m_acc[15:8];
        e.act = (m_mode != M_IDLE);
        e.fd  = m_fd;
        return e;
    endfunction

    task automatic apply(input bit tick, input bit on, input bit off, input int inc);
        exp_t e;
        seq_if.sample_tick = tick;
        seq_if.note_on     = on;
        seq_if.note_off    = off;
        // Junk on increment outside note_on proves it is sampled only then.
        seq_if.increment   = on ? inc[15:0] : 16'($urandom);
        model_step(tick, on, off, inc);
        sb_q.push_back(model_out());
        @(posedge clock);
        #1;
        seq_if.sample_tick = 1'b0;
        seq_if.note_on     = 1'b0;
        seq_if.note_off    = 1'b0;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("state", 32'(seq_if.state), 32'(e.st));
            check("phase", 32'(seq_if.phase), 32'(e.ph));
            check("active", 32'(seq_if.active), 32'(e.act));
            check("front_done", 32'(seq_if.front_done), 32'(e.fd));
        end
        if (seq_if.front_done === 1'b1) fd_seen++;
    endtask

    task automatic tick_step();
        apply(1'b1, 1'b0, 1'b0, 0);
        apply(1'b0, 1'b0, 1'b0, 0);
        apply(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        int fd_base;
        int guard;
        seq_if.sample_tick = 1'b0;
        seq_if.note_on     = 1'b0;
        seq_if.note_off    = 1'b0;
        seq_if.increment   = '0;
        model_reset();

        // Reset values, then 100 idle cycles after release.
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", 32'(seq_if.state), 32'(FRONT));
        check("rst_phase", 32'(seq_if.phase), 32'd0);
        check("rst_active", 32'(seq_if.active), 32'd0);
        check("rst_front_done", 32'(seq_if.front_done), 32'd0);
        reset_n = 1'b1;
        repeat (100) apply(1'b0, 1'b0, 1'b0, 0);

        // Integer-step attack: phase 1..255 in FRONT, wrap into BACK at tick 256.
        apply(1'b0, 1'b1, 1'b0, 32'h0100);
        check("note_on_active", 32'(seq_if.active), 32'd1);
        for (int i = 1; i <= 255; i++) begin
            tick_step();
            check("ramp_phase", 32'(seq_if.phase), 32'(i));
        end
        check("ramp_state_front", 32'(seq_if.state), 32'(FRONT));
        tick_step();
        check("wrap_state_back", 32'(seq_if.state), 32'(BACK));
        check("wrap_phase_zero", 32'(seq_if.phase), 32'd0);
        check("front_done_once", 32'(fd_seen), 32'd1);

        // Fractional step restarted from BACK; remainder carried, BACK loops quietly.
        fd_base = fd_seen;
        apply(1'b0, 1'b1, 1'b0, 32'h0180);
        check("restart_state", 32'(seq_if.state), 32'(FRONT));
        for (int i = 0; i < 1000; i++) tick_step();
        check("loop_front_done_count", 32'(fd_seen - fd_base), 32'd1);
        check("loop_state_back", 32'(seq_if.state), 32'(BACK));

        // Release from BACK at phase 0x40.
        apply(1'b0, 1'b1, 1'b0, 32'h0100);
        for (int i = 0; i < 256 + 64; i++) tick_step();
        check("pre_release_phase", 32'(seq_if.phase), 32'h40);
        apply(1'b0, 1'b0, 1'b1, 0);
`ifdef HORN_SOFT_RELEASE_EN
        check("soft_release_active", 32'(seq_if.active), 32'd1);
        check("soft_release_state", 32'(seq_if.state), 32'(BACK));
        guard = 0;
        while (seq_if.active === 1'b1 && guard < 300) begin
            tick_step();
            guard++;
        end
        check("soft_release_bound", 32'(guard < 300), 32'd1);
        check("soft_release_ticks", 32'(guard), 32'd192);
`else
        guard = 0;
`endif
        check("release_active", 32'(seq_if.active), 32'd0);
        check("release_phase", 32'(seq_if.phase), 32'd0);
        check("release_state", 32'(seq_if.state), 32'(FRONT));

        // note_off in IDLE is ignored; then note_on+note_off together in BACK restarts.
        apply(1'b0, 1'b0, 1'b1, 0);
        apply(1'b0, 1'b1, 1'b0, 32'h4000);
        for (int i = 0; i < 5; i++) tick_step();
        check("fast_back_phase", 32'(seq_if.phase), 32'h40);
        apply(1'b0, 1'b1, 1'b1, 32'h0200);
        check("on_off_state", 32'(seq_if.state), 32'(FRONT));
        check("on_off_phase", 32'(seq_if.phase), 32'd0);
        check("on_off_active", 32'(seq_if.active), 32'd1);

        // Strobes coincident with sample_tick suppress the accumulate.
        tick_step();
        apply(1'b1, 1'b1, 1'b0, 32'h0300);
        check("tick_on_phase", 32'(seq_if.phase), 32'd0);
        tick_step();
        tick_step();
        apply(1'b1, 1'b0, 1'b1, 0);
        check("tick_off_active", 32'(seq_if.active), 32'd0);

        // Zero increment holds phase and never leaves FRONT.
        apply(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) tick_step();
        check("zero_inc_phase", 32'(seq_if.phase), 32'd0);
        check("zero_inc_state", 32'(seq_if.state), 32'(FRONT));

        // Asynchronous reset mid-FRONT at phase 0x33, checked before the next edge.
        apply(1'b0, 1'b1, 1'b0, 32'h0100);
        for (int i = 0; i < 'h33; i++) tick_step();
        check("pre_reset_phase", 32'(seq_if.phase), 32'h33);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_state", 32'(seq_if.state), 32'(FRONT));
        check("async_rst_phase", 32'(seq_if.phase), 32'd0);
        check("async_rst_active", 32'(seq_if.active), 32'd0);
        check("async_rst_front_done", 32'(seq_if.front_done), 32'd0);
        model_reset();
        sb_q.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (5) apply(1'b0, 1'b0, 1'b0, 0);
        tick_step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
